// File: rtl/slowdoor_cfg_pkg.sv
// slowdoor_cfg_pkg: shared types and constants for the SlowDoor configuration loader.
// Optional feature macro used by the loader: SLOWDOOR_CFG_PARITY_EN (odd parity on in_data).
package slowdoor_cfg_pkg;

  // Loader control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  // Routing modes understood by a logic block; anything above MODE_MAX is illegal
  localparam logic [2:0] MODE_CD   = 3'd0;
  localparam logic [2:0] MODE_CE   = 3'd1;
  localparam logic [2:0] MODE_BD_E = 3'd2;
  localparam logic [2:0] MODE_DE_B = 3'd3;
  localparam logic [2:0] MODE_BC_D = 3'd4;
  localparam logic [2:0] MODE_BD_C = 3'd5;
  localparam logic [2:0] MODE_MAX  = 3'd5;

  // Error codes reported on err_code
  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_MODE   = 2'd1;
  localparam logic [1:0] ERR_PARITY = 2'd2;

  // True when the byte carries odd parity over all eight bits
  function automatic logic odd_parity_ok(input logic [7:0] b);
    return ((^b) == 1'b1);
  endfunction

endpackage

// File: rtl/slowdoor_cfg_word_check.sv
// slowdoor_cfg_word_check: splits a config byte into mode/lut and classifies it.
// With SLOWDOOR_CFG_PARITY_EN defined, bit 7 must give the byte odd parity;
// otherwise bit 7 is ignored. An illegal mode is reported ahead of a parity error.
module slowdoor_cfg_word_check
  import slowdoor_cfg_pkg::*;
(
  input  logic [7:0] data,
  output logic [2:0] mode,
  output logic [3:0] lut,
  output logic       ok,
  output logic [1:0] code
);

`ifndef SLOWDOOR_CFG_PARITY_EN
  logic unused_parity_bit_s;
  assign unused_parity_bit_s = data[7];
`endif

  // Field decode and validity classification, mode check first
  always_comb begin
    mode = data[6:4];
    lut  = data[3:0];
    ok   = 1'b1;
    code = ERR_NONE;
    if (data[6:4] > MODE_MAX) begin
      ok   = 1'b0;
      code = ERR_MODE;
    end else begin
`ifdef SLOWDOOR_CFG_PARITY_EN
      if (!odd_parity_ok(data)) begin
        ok   = 1'b0;
        code = ERR_PARITY;
      end else begin
        ok   = 1'b1;
        code = ERR_NONE;
      end
`else
      ok   = 1'b1;
      code = ERR_NONE;
`endif
    end
  end

endmodule

// File: rtl/slowdoor_cfg_loader.sv
// slowdoor_cfg_loader: streams config bytes into sequential logic-block addresses
// and raises array_en once every block has been written without error.
// Optional feature macro: SLOWDOOR_CFG_PARITY_EN (handled in slowdoor_cfg_word_check).
module slowdoor_cfg_loader
  import slowdoor_cfg_pkg::*;
#(
  parameter int NUM_BLOCKS = 16,
  parameter int AW         = $clog2(NUM_BLOCKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          cfg_we,
  output logic [AW-1:0] cfg_addr,
  output logic [2:0]    cfg_mode,
  output logic [3:0]    cfg_lut,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic          array_en
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BLOCKS - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1'b1);

  state_t        state_r, state_n;
  logic [AW-1:0] cnt_r, cnt_n;
  logic          we_r, we_n;
  logic [AW-1:0] addr_r, addr_n;
  logic [2:0]    mode_r, mode_n;
  logic [3:0]    lut_r, lut_n;
  logic [1:0]    code_r, code_n;
  logic          busy_r, done_r, err_r;

  logic [2:0]    chk_mode_s;
  logic [3:0]    chk_lut_s;
  logic          chk_ok_s;
  logic [1:0]    chk_code_s;
  logic          in_ready_s;
  logic          accept_s;

  slowdoor_cfg_word_check u_check (
    .data (in_data),
    .mode (chk_mode_s),
    .lut  (chk_lut_s),
    .ok   (chk_ok_s),
    .code (chk_code_s)
  );

  // Ready is withheld during abort so an arriving byte is never taken
  assign in_ready_s = (state_r == ST_LOAD) && !abort;
  assign accept_s   = in_valid && in_ready_s;

  // Next-state, counter and write-port decisions; abort overrides everything
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    we_n    = 1'b0;
    addr_n  = addr_r;
    mode_n  = mode_r;
    lut_n   = lut_r;
    code_n  = code_r;
    if (abort) begin
      state_n = ST_IDLE;
      code_n  = ERR_NONE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_n = ST_LOAD;
            cnt_n   = '0;
            code_n  = ERR_NONE;
          end else begin
            state_n = state_r;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            if (chk_ok_s) begin
              we_n   = 1'b1;
              addr_n = cnt_r;
              mode_n = chk_mode_s;
              lut_n  = chk_lut_s;
              if (cnt_r == LAST_ADDR) begin
                state_n = ST_DONE;
              end else begin
                cnt_n = cnt_r + ADDR_ONE;
              end
            end else begin
              state_n = ST_ERROR;
              code_n  = chk_code_s;
            end
          end else begin
            state_n = ST_LOAD;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter and registered outputs; status flags track the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      mode_r  <= 3'd0;
      lut_r   <= 4'd0;
      code_r  <= ERR_NONE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      we_r    <= we_n;
      addr_r  <= addr_n;
      mode_r  <= mode_n;
      lut_r   <= lut_n;
      code_r  <= code_n;
      busy_r  <= (state_n == ST_LOAD);
      done_r  <= (state_n == ST_DONE);
      err_r   <= (state_n == ST_ERROR);
    end
  end

  assign in_ready = in_ready_s;
  assign cfg_we   = we_r;
  assign cfg_addr = addr_r;
  assign cfg_mode = mode_r;
  assign cfg_lut  = lut_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign err_code = code_r;
  assign array_en = done_r;

endmodule

// File: doc/slowdoor_cfg_loader.md
Name: slowdoor_cfg_loader

Overview:
- Configuration loader for the SlowDoor logic-block array.
- Accepts a byte stream over a valid/ready handshake and validates each byte.
- Writes each block's 3-bit routing mode and 4-bit LUT2 truth table into sequential block addresses.
- Asserts array enable only after every block has been programmed without error.

Parameters:
- NUM_BLOCKS, 16, number of logic blocks to program; legal range 2..256.
- AW, $clog2(NUM_BLOCKS), width of the block address.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- abort  input  1  returns to IDLE next cycle from any state.
- in_data  input  8  config byte: [7] parity/ignored, [6:4] mode, [3:0] lut.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts the byte this cycle.
- cfg_we  output  1  one-cycle write strobe to the addressed block's config registers.
- cfg_addr  output  AW  target block index.
- cfg_mode  output  3  routing mode to write.
- cfg_lut  output  4  LUT2 truth table to write.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE.
- err  output  1  high in ERROR.
- err_code  output  2  0=none, 1=illegal mode, 2=parity.
- array_en  output  1  equals done; gates the logic-block array.

Behaviour:
- Reset: state=IDLE; all outputs 0; address counter 0.
- States are IDLE, LOAD, DONE, ERROR.
- IDLE -> LOAD on start: address counter cleared; err_code cleared.
- DONE -> LOAD and ERROR -> LOAD on start: same clears as from IDLE; done/array_en drop in the cycle LOAD is entered.
- in_ready=1 only in LOAD and when abort=0. A byte is accepted when in_valid & in_ready.
- Byte valid when mode is 0..5. Mode 6 or 7 is illegal.
- Accepted valid byte in cycle N:
  - cycle N+1: cfg_we=1 with cfg_addr = counter value at N, and cfg_mode/cfg_lut from the byte.
  - counter increments at N+1.
- cfg_we is 0 in every other cycle; cfg_addr/cfg_mode/cfg_lut hold their last values.
- Last block accepted (counter = NUM_BLOCKS-1): state=DONE at N+1, the same cycle as the final cfg_we; counter does not wrap.
- Accepted invalid byte at N: no write; state=ERROR at N+1 with err_code set; counter frozen.
- Mode check has priority over the parity check (parity only with the optional feature).
- in_valid low in LOAD: stall indefinitely; no timeout.
- start while in LOAD is ignored.
- abort in any state, including the cycle a byte arrives: the byte is not accepted (in_ready=0); state=IDLE next cycle.
  - Outputs clear on the abort transition, except cfg_addr/cfg_mode/cfg_lut, which hold.
  - Blocks already written keep their contents.
- abort and start in the same cycle: abort wins.
- rst mid-LOAD: identical to power-up reset; cfg_we does not fire for a byte in flight.
- DONE and ERROR hold until start, abort or rst.

Optional Feature:
- Macro: SLOWDOOR_CFG_PARITY_EN.
- Defined: in_data[7] must make the XOR of in_data[7:0] equal 1 (odd parity). On mismatch with a legal mode, enter ERROR with err_code=2.
- Undefined: bit 7 is ignored and err_code=2 is never produced.

Decomposition:
- Package slowdoor_cfg_pkg holds:
  - state enum;
  - mode constants MODE_CD=0, MODE_CE=1, MODE_BD_E=2, MODE_DE_B=3, MODE_BC_D=4, MODE_BD_C=5, MODE_MAX=5;
  - error-code constants ERR_NONE, ERR_MODE, ERR_PARITY.
- One combinational sub-module, slowdoor_cfg_word_check, decodes the byte into mode and lut and produces ok and code. It contains the parity logic under the macro.
- FSM, counter and output registers live in the top module.

Test Plan:
- Full load, NUM_BLOCKS=4: start, then bytes 0x0A, 0x15, 0x2F, 0x53 sent back-to-back with parity off -> four cfg_we pulses at addr 0..3, one cycle after each accept, with mode/lut 0/A, 1/5, 2/F, 5/3. done and array_en go high in the same cycle as the last cfg_we.
- Backpressure: in_valid toggling 1,0,0,1 -> cfg_we only follows accepted bytes; the address sequence has no gaps.
- Illegal mode: byte 0x6C sent as the 2nd byte -> single cfg_we at addr 0, then ERROR with err_code=1, in_ready=0 and no further writes. Then start -> LOAD with addr 0 and err cleared.
- Abort: abort asserted together with in_valid mid-load after 2 writes -> no 3rd cfg_we; IDLE next cycle; busy=0, array_en=0.
- Parity, built with SLOWDOOR_CFG_PARITY_EN: byte 0x0A (even parity) -> ERROR with err_code=2. Byte 0x8A -> accepted. Byte 0x70 -> err_code=1, mode error wins.
- Reset during LOAD: rst asserted in the same cycle a byte is accepted -> no cfg_we the next cycle; all outputs 0; start restarts at addr 0.
